mem_access: RTL

Memory-access stage of the five-stage RV32I pipeline, between the EX_MEM and MEM_WB registers. Executes loads and stores over the 8-bit single-port RAM interface, one byte per cycle, little-endian. Stalls the pipeline until the access completes. Passes non-memory instructions through unchanged with zero added latency.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_load_ext.sv | 21 ++
 rtl/mem_access.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: instruction indices, FSM states, RAM width.
package mem_access_pkg;

  localparam int INST_IDX_W = 6;
  localparam int RAM_W      = 8;

  typedef logic [INST_IDX_W-1:0] inst_idx_t;

  localparam inst_idx_t idNOP = 6'd0;
  localparam inst_idx_t idADD = 6'd1;
  localparam inst_idx_t idLB  = 6'd10;
  localparam inst_idx_t idLH  = 6'd11;
  localparam inst_idx_t idLW  = 6'd12;
  localparam inst_idx_t idLBU = 6'd13;
  localparam inst_idx_t idLHU = 6'd14;
  localparam inst_idx_t idSB  = 6'd15;
  localparam inst_idx_t idSH  = 6'd16;
  localparam inst_idx_t idSW  = 6'd17;

  typedef enum logic [1:0] {
    memIDLE = 2'd0,
    memREQ  = 2'd1,
    memXFER = 2'd2,
    memDONE = 2'd3
  } mem_state_e;

  function automatic logic is_load(input inst_idx_t idx);
    return (idx == idLB) || (idx == idLH) || (idx == idLW) ||
           (idx == idLBU) || (idx == idLHU);
  endfunction

  function automatic logic is_store(input inst_idx_t idx);
    return (idx == idSB) || (idx == idSH) || (idx == idSW);
  endfunction

  function automatic logic [2:0] byte_count(input inst_idx_t idx);
    case (idx)
      idLB, idLBU, idSB: return 3'd1;
      idLH, idLHU, idSH: return 3'd2;
      idLW, idSW:        return 3'd4;
      default:           return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the assembled little-endian load buffer.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] raw,
  input  inst_idx_t   inst_idx,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (inst_idx)
      idLB:    ext = {{24{raw[7]}}, raw[7:0]};
      idLH:    ext = {{16{raw[15]}}, raw[15:0]};
      idLBU:   ext = {24'd0, raw[7:0]};
      idLHU:   ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: bytewise loads/stores over an 8-bit RAM, stalling until done.
// Optional MEM_FAST_GRANT_EN skips REQ when the bus is already granted in IDLE.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  inst_idx_t         instIdx_in,
  input  logic [31:0]       memAddr_in,
  input  logic [31:0]       valStore_in,
  input  logic              rdE_in,
  input  logic [4:0]        rdIdx_in,
  input  logic [31:0]       rdData_in,
  output logic              rdE_out,
  output logic [4:0]        rdIdx_out,
  output logic [31:0]       rdData_out,
  output logic              stall_out,
  output logic              memReq_out,
  input  logic              memGrant_in,
  output logic [ADDR_W-1:0] ramAddr_out,
  output logic              ramWe_out,
  output logic [RAM_W-1:0]  ramData_out,
  input  logic [RAM_W-1:0]  ramData_in
);

  mem_state_e  state, next_state;
  logic [2:0]  cnt, next_cnt, cnt_m1, n_bytes;
  logic [31:0] load_buf, next_buf, byte_addr, load_ext;
  logic        load_op, store_op, mem_op;
  logic        unused_addr_hi;

  assign load_op   = is_load(instIdx_in);
  assign store_op  = is_store(instIdx_in);
  assign mem_op    = load_op | store_op;
  assign n_bytes   = byte_count(instIdx_in);
  assign byte_addr = memAddr_in + {29'd0, cnt};
  assign cnt_m1    = cnt - 3'd1;
  assign unused_addr_hi = ^byte_addr[31:ADDR_W];

  // Gated by reset so the pipeline is never frozen while the stage is held in reset.
  assign stall_out = rst_in & mem_op & (state != memDONE);

  mem_load_ext u_load_ext (
    .raw      (load_buf),
    .inst_idx (instIdx_in),
    .ext      (load_ext)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= memIDLE;
      cnt      <= 3'd0;
      load_buf <= 32'd0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      load_buf <= next_buf;
    end
  end

  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_buf    = load_buf;
    memReq_out  = 1'b0;
    ramWe_out   = 1'b0;
    ramAddr_out = '0;
    ramData_out = '0;
    rdE_out     = rdE_in;
    rdIdx_out   = rdIdx_in;
    rdData_out  = rdData_in;

    if (!mem_op) begin
      next_state = memIDLE;
      next_cnt   = 3'd0;
    end else begin
      case (state)
        memIDLE: begin
          next_cnt = 3'd0;
`ifdef MEM_FAST_GRANT_EN
          memReq_out = rst_in;
          next_state = memGrant_in ? memXFER : memREQ;
`else
          next_state = memREQ;
`endif
        end
        memREQ: begin
          memReq_out = 1'b1;
          next_cnt   = 3'd0;
          if (memGrant_in) next_state = memXFER;
        end
        memXFER: begin
          memReq_out = 1'b1;
          if (store_op) begin
            ramWe_out   = 1'b1;
            ramAddr_out = byte_addr[ADDR_W-1:0];
            ramData_out = valStore_in[{cnt[1:0], 3'b000} +: 8];
            if (cnt == n_bytes - 3'd1) next_state = memDONE;
            else                       next_cnt   = cnt + 3'd1;
          end else begin
            // Read data lags its address by one cycle, hence the extra cnt = N beat.
            if (cnt < n_bytes) ramAddr_out = byte_addr[ADDR_W-1:0];
            if (cnt != 3'd0) next_buf[{cnt_m1[1:0], 3'b000} +: 8] = ramData_in;
            if (cnt == n_bytes) next_state = memDONE;
            else                next_cnt   = cnt + 3'd1;
          end
        end
        memDONE: begin
          next_state = memIDLE;
          next_cnt   = 3'd0;
          if (load_op) rdData_out = load_ext;
          else         rdE_out    = 1'b0;
        end
        default: next_state = memIDLE;
      endcase
    end
  end

endmodule
